ram_bus_master: RTL and testbench
=================================

// Module: ram_bus_master
// PURPOSE
//  Initiator for the shared single-port synchronous RAM bus (addr / tristate data / cs / we / oe).
//  Accepts one word request at a time on a valid/ready front end and sequences the chip-select,
//  write-enable and output-enable timing. Owns the data-bus direction.
//  Read data returns on a one-cycle response pulse. Sits between CPU/ALU datapath and the banked RAM.
// PARAMETERS
//  ADDR_WIDTH  15  word address width; passed through unchanged (RAM decodes top 2 bits to bank)
//  DATA_WIDTH  16  data bus / request / response word width
// PORTS
//  clk        in    1           single clock; all state changes on posedge
//  rst_n      in    1           asynchronous, active-low reset
//  req_valid  in    1           request present
//  req_ready  out   1           master idle, can accept request
//  req_we     in    1           1 = write, 0 = read
//  req_addr   in    ADDR_WIDTH  word address
//  req_wdata  in    DATA_WIDTH  write data
//  rsp_valid  out   1           one-cycle completion pulse (reads and writes)
//  rsp_rdata  out   DATA_WIDTH  read data; valid while rsp_valid=1
//  rsp_err    out   1           read-back mismatch flag (RAM_MASTER_RDBK_EN only, else tied 0)
//  mem_addr   out   ADDR_WIDTH  RAM address
//  mem_data   inout DATA_WIDTH  RAM data bus; driven only in WR state, else high-Z
//  mem_cs     out   1           RAM chip select (active high)
//  mem_we     out   1           RAM write enable (active high)
//  mem_oe     out   1           RAM output enable (active high)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//    mem_cs=mem_we=mem_oe=0, mem_addr=0, mem_data high-Z. Reset mid-operation aborts the access.
//    No retry.
//  - All mem_* controls and rsp_* outputs registered. Request fields latched on accept edge.
//  - Accept: edge where req_valid & req_ready. req_ready=1 only in IDLE.
//  - FSM IDLE->WR->IDLE (write); IDLE->RD_ADDR->RD_CAP->IDLE (read).
//  - WR: cs=1 we=1 oe=0, mem_data driven with latched wdata. RAM writes on exit edge.
//    Then rsp_valid=1 for one cycle with IDLE.
//  - RD_ADDR: cs=1 we=0 oe=1, bus released. RAM registers the word on the exit edge.
//  - RD_CAP: same controls. Master samples mem_data into rsp_rdata on the exit edge.
//    rsp_valid=1 next cycle.
//  - Latency accept-edge to rsp_valid high: write 2 cycles, read 3 cycles.
//  - Back-to-back: the rsp_valid cycle is an IDLE cycle, so a new request may be accepted on it.
//  - Bus rules: mem_data drive and mem_oe never both 1 in the same cycle. mem_we=1 only in WR.
//    cs=0 in IDLE.
//  - rsp_rdata holds its last read value through writes and idle.
//  - req_* changes while not ready are ignored. req_valid held high gives continuous service.
//  - Address boundaries 0x0000 and 0x7FFF (all banks) are issued unmodified. No wrap logic.
// CONFIGURATION
//  RAM_MASTER_RDBK_EN defined: each write is followed by read-back.
//    FSM is WR->RB_ADDR->RB_CAP->IDLE, with RD_ADDR/RD_CAP timing.
//    Write latency is 4 cycles. rsp_rdata = read-back word.
//    rsp_err=1 with rsp_valid if read-back != wdata, else 0. rsp_err=0 on reads.
//  Undefined: no RB states; write latency 2; rsp_err constant 0.
// TESTING
//  1. Reset: rst_n=0 mid-read (RD_ADDR) -> same cycle: cs/we/oe=0, bus Z, req_ready=1,
//     rsp_valid=0, rsp_rdata=0.
//  2. Write 0xA5C3 @0x0012, then read 0x0012 -> write rsp_valid 2 cycles after accept;
//     read rsp_valid 3 cycles after accept, rsp_rdata=0xA5C3.
//  3. Bank sweep: write addr 0x0000/0x2000/0x4000/0x7FFF with 0x1111/0x2222/0x3333/0xFFFF,
//     read back -> exact values, no aliasing.
//  4. req_valid held high, alternating W/R of 8 words -> one accept per rsp_valid cycle,
//     no lost/duplicate access.
//  5. Bus monitor all tests: never mem_oe=1 while master drives mem_data;
//     mem_data never X when sampled in RD_CAP.
//  6. RAM_MASTER_RDBK_EN: write 0x00FF with RAM bit 3 forced stuck -> rsp_err=1,
//     rsp_rdata=0x00F7, rsp_valid 4 cycles after accept.

Source files
------------

// File: rtl/ram_bus_master.sv
// Single-request initiator for the shared synchronous RAM bus: sequences cs/we/oe and owns mem_data direction.
// Optional feature macro RAM_MASTER_RDBK_EN: every write is verified by a read-back; mismatches raise rsp_err.
module ram_bus_master #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_CAP  = 3'd3,
        RB_ADDR = 3'd4,
        RB_CAP  = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    drive_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    cs_d, we_d, oe_d, done, capture;

    assign req_ready = (state_q == IDLE);
    // The master only drives the bus while the registered write strobe is up.
    assign mem_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = req_we ? WR : RD_ADDR;
`ifdef RAM_MASTER_RDBK_EN
            WR:      state_d = RB_ADDR;
`else
            WR:      state_d = IDLE;
`endif
            RD_ADDR: state_d = RD_CAP;
            RD_CAP:  state_d = IDLE;
            RB_ADDR: state_d = RB_CAP;
            RB_CAP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus controls are computed from the next state so the registered pins line up with the state they belong to.
    always_comb begin
        cs_d    = (state_d != IDLE);
        we_d    = (state_d == WR);
        oe_d    = (state_d == RD_ADDR) || (state_d == RD_CAP) ||
                  (state_d == RB_ADDR) || (state_d == RB_CAP);
        done    = (state_q != IDLE) && (state_d == IDLE);
        capture = (state_q == RD_CAP) || (state_q == RB_CAP);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            drive_q   <= 1'b0;
            mem_addr  <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_d;
            mem_cs    <= cs_d;
            mem_we    <= we_d;
            mem_oe    <= oe_d;
            drive_q   <= we_d;
            rsp_valid <= done;
            if (req_valid && req_ready) begin
                mem_addr <= req_addr;
                wdata_q  <= req_wdata;
            end
            if (capture) rsp_rdata <= mem_data;
        end
    end

`ifdef RAM_MASTER_RDBK_EN
    // Error is only ever high alongside the write's completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rsp_err <= 1'b0;
        else        rsp_err <= (state_q == RB_CAP) && (mem_data != wdata_q);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: behavioural RAM on the bus, directed table, streaming and random traffic.
// Build with RAM_MASTER_RDBK_EN defined to exercise the write read-back variant.
module tb_ram_bus_master;

`ifdef RAM_MASTER_RDBK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int WLAT = RB ? 4 : 2;
    localparam int RLAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [14:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [14:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_cs, mem_we, mem_oe;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ram_bus_master #(.ADDR_WIDTH(15), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    // Behavioural synchronous RAM: registers the word on an oe edge, presents it while oe stays high.
    logic [15:0] ram [0:32767];
    logic [15:0] ram_q = '0;
    logic        ram_drv = 1'b0;
    logic [15:0] stuck = '0;

    initial for (int i = 0; i < 32768; i++) ram[i] = '0;

    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_addr] <= mem_data & ~stuck;
        ram_drv <= mem_cs && mem_oe && !mem_we;
        if (mem_cs && mem_oe && !mem_we) ram_q <= ram[mem_addr];
    end
    assign mem_data = (ram_drv && mem_oe) ? ram_q : 16'bz;

    // Bus monitor
    int bus_viol = 0;
    int x_viol = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_oe && mem_we) bus_viol++;
            if (!mem_cs && (mem_we || mem_oe)) bus_viol++;
            if (ram_drv && mem_oe && $isunknown(mem_data)) x_viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: word-addressed memory plus the last value returned by a read.
    logic [15:0] model_mem [logic [14:0]];
    logic [15:0] last_rd = '0;

    function automatic logic [15:0] ref_access(input logic we, input logic [14:0] a, input logic [15:0] d);
        if (we) begin
            model_mem[a] = d;
            if (RB) last_rd = d;
        end else begin
            last_rd = model_mem.exists(a) ? model_mem[a] : 16'h0000;
        end
        return last_rd;
    endfunction

    task automatic txn(input string name, input logic we, input logic [14:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp_rdata, input logic exp_err);
        int n;
        int lat;
        int exp_lat;
        exp_lat = we ? WLAT : RLAT;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check($sformatf("%s/ready", name), {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble the request fields; the master must have latched them.
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
        lat = 0;
        do begin
            @(negedge clk); lat++;
            if (lat == 1) check($sformatf("%s/addr", name), {17'd0, mem_addr}, {17'd0, addr});
        end while (!rsp_valid && lat < 10);
        check($sformatf("%s/lat", name), lat, exp_lat);
        check($sformatf("%s/rdata", name), {16'd0, rsp_rdata}, {16'd0, exp_rdata});
        check($sformatf("%s/err", name), {31'd0, rsp_err}, {31'd0, exp_err});
        @(negedge clk);
        check($sformatf("%s/pulse", name), {31'd0, rsp_valid}, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic reset_test();
        txn("pre_w", 1'b1, 15'h0100, 16'h5A5A, RB ? 16'h5A5A : 16'h0000, 1'b0);
        void'(ref_access(1'b1, 15'h0100, 16'h5A5A));
        txn("pre_r", 1'b0, 15'h0100, 16'h0000, 16'h5A5A, 1'b0);
        void'(ref_access(1'b0, 15'h0100, 16'h0000));
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst/in_rd_addr", {31'd0, mem_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst/cs", {31'd0, mem_cs}, 32'd0);
        check("rst/we", {31'd0, mem_we}, 32'd0);
        check("rst/oe", {31'd0, mem_oe}, 32'd0);
        check("rst/ready", {31'd0, req_ready}, 32'd1);
        check("rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst/rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst/err", {31'd0, rsp_err}, 32'd0);
        check("rst/addr", {17'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst/aborted", {31'd0, rsp_valid}, 32'd0);
        end
        last_rd = 16'h0000;
    endtask

    task automatic stream_test();
        logic        s_we [8];
        logic [14:0] s_a  [8];
        logic [15:0] s_d  [8];
        logic [15:0] exp_q [$];
        int i = 0, nrsp = 0, cyc = 0, seq_viol = 0, err_seen = 0;
        logic accepting;
        for (int k = 0; k < 8; k++) begin
            s_we[k] = (k % 2 == 0);
            s_a[k]  = 15'h0300 + 15'(k / 2);
            s_d[k]  = 16'($urandom);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = s_we[0]; req_addr = s_a[0]; req_wdata = s_d[0];
        while (nrsp < 8 && cyc < 200) begin
            if (rsp_valid) begin
                nrsp++;
                if (rsp_err) err_seen++;
                if (!req_ready) seq_viol++;
                if (i < 8 && !(req_valid && req_ready)) seq_viol++;
                if (exp_q.size() == 0) seq_viol++;
                else check($sformatf("stream/rdata%0d", nrsp), {16'd0, rsp_rdata}, {16'd0, exp_q.pop_front()});
            end
            accepting = req_valid && req_ready;
            @(posedge clk); #1;
            if (accepting) begin
                exp_q.push_back(ref_access(s_we[i], s_a[i], s_d[i]));
                i++;
                if (i < 8) begin
                    req_we = s_we[i]; req_addr = s_a[i]; req_wdata = s_d[i];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk); cyc++;
        end
        req_valid = 1'b0;
        check("stream/accepts", i, 8);
        check("stream/responses", nrsp, 8);
        check("stream/order", seq_viol, 0);
        check("stream/err", err_seen, 0);
    endtask

    task automatic random_test();
        logic [14:0] pool [4];
        logic        we;
        logic [14:0] a;
        logic [15:0] d, e;
        for (int k = 0; k < 4; k++) pool[k] = 15'h0400 + 15'(k * 15'h0801);
        for (int k = 0; k < 4; k++) begin
            d = 16'($urandom);
            e = ref_access(1'b1, pool[k], d);
            txn($sformatf("rnd_init%0d", k), 1'b1, pool[k], d, e, 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            we = 1'($urandom_range(0, 1));
            a  = pool[$urandom_range(0, 3)];
            d  = 16'($urandom);
            e  = ref_access(we, a, d);
            txn($sformatf("rnd%0d", k), we, a, d, e, 1'b0);
        end
    endtask

    initial begin
        vec_t vecs [10];
        vecs[0] = '{1'b1, 15'h0012, 16'hA5C3, RB ? 16'hA5C3 : 16'h0000};
        vecs[1] = '{1'b0, 15'h0012, 16'h0000, 16'hA5C3};
        vecs[2] = '{1'b1, 15'h0000, 16'h1111, RB ? 16'h1111 : 16'hA5C3};
        vecs[3] = '{1'b1, 15'h2000, 16'h2222, RB ? 16'h2222 : 16'hA5C3};
        vecs[4] = '{1'b1, 15'h4000, 16'h3333, RB ? 16'h3333 : 16'hA5C3};
        vecs[5] = '{1'b1, 15'h7FFF, 16'hFFFF, RB ? 16'hFFFF : 16'hA5C3};
        vecs[6] = '{1'b0, 15'h0000, 16'h0000, 16'h1111};
        vecs[7] = '{1'b0, 15'h2000, 16'h0000, 16'h2222};
        vecs[8] = '{1'b0, 15'h4000, 16'h0000, 16'h3333};
        vecs[9] = '{1'b0, 15'h7FFF, 16'h0000, 16'hFFFF};

        repeat (3) @(negedge clk);
        check("reset/ready", {31'd0, req_ready}, 32'd1);
        check("reset/cs", {31'd0, mem_cs}, 32'd0);
        rst_n = 1'b1;

        reset_test();

        for (int k = 0; k < 10; k++) begin
            txn($sformatf("vec%0d", k), vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].exp_rdata, 1'b0);
            void'(ref_access(vecs[k].we, vecs[k].addr, vecs[k].wdata));
        end

        stream_test();
        random_test();

`ifdef RAM_MASTER_RDBK_EN
        stuck = 16'h0008;
        txn("rdbk_stuck", 1'b1, 15'h0500, 16'h00FF, 16'h00F7, 1'b1);
        stuck = 16'h0000;
        txn("rdbk_clean", 1'b1, 15'h0501, 16'h00FF, 16'h00FF, 1'b0);
        txn("rdbk_read", 1'b0, 15'h0500, 16'h0000, 16'h00F7, 1'b0);
`endif

        check("bus_monitor", bus_viol, 0);
        check("bus_x", x_viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
